// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - Parametrised multi-cycle ALU with MIPS funct codes, iterative MULT/DIV
// Ports: clk, rst (async active-high); request in_valid/in_ready with op, in0, in1, shamt;
// result out_valid/out_ready with out (LO/quotient), hi (HI/remainder) and flags
// overflow, zero, carryout, illegal; busy is high whenever the FSM is not IDLE.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             overflow,
    output logic             zero,
    output logic             carryout,
    output logic             illegal,
    output logic             busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] OP_SLL  = 6'b000000, OP_SRL  = 6'b000010, OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SLLV = 6'b000100, OP_SRLV = 6'b000110, OP_SRAV = 6'b000111;
    localparam logic [5:0] OP_MULT = 6'b011000, OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV  = 6'b011010, OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_ADD  = 6'b100000, OP_ADDU = 6'b100001;
    localparam logic [5:0] OP_SUB  = 6'b100010, OP_SUBU = 6'b100011;
    localparam logic [5:0] OP_AND  = 6'b100100, OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110, OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLT  = 6'b101010, OP_SLTU = 6'b101011;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_q, acc_d;   // product high half or partial remainder
    logic [WIDTH-1:0] b_q, b_d;       // multiplier/product low half or dividend/quotient
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;         // product/quotient must be negated
    logic             neg_rem_q, neg_rem_d; // remainder takes the dividend's sign
    logic             div_ovf_q, div_ovf_d;
    logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d;
    logic             ovf_q, ovf_d, zero_q, zero_d, cout_q, cout_d, ill_q, ill_d;

    logic             accept;
    logic [WIDTH:0]   sum, diff;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] sc_out, sc_hi;
    logic             sc_ovf, sc_cout, sc_ill, multi;
    logic             s0, s1;
    logic [WIDTH-1:0] mag0, mag1;
    logic [WIDTH:0]   mul_sum, rem_sh, trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out       = out_q;
    assign hi        = hi_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign carryout  = cout_q;
    assign illegal   = ill_q;

    assign sum     = {1'b0, in0} + {1'b0, in1};
    assign diff    = {1'b0, in0} - {1'b0, in1};
    assign add_ovf = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
    assign sub_ovf = (in0[WIDTH-1] != in1[WIDTH-1]) && (diff[WIDTH-1] != in0[WIDTH-1]);

    // Operand magnitudes for the signed multiply/divide; op[0] clear means signed.
    assign s0   = ~op[0] & in0[WIDTH-1];
    assign s1   = ~op[0] & in1[WIDTH-1];
    assign mag0 = s0 ? -in0 : in0;
    assign mag1 = s1 ? -in1 : in1;

    // One shift-add step and one restoring-division step.
    assign mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign rem_sh  = {acc_q, b_q[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, a_q};

    assign prod_fix = neg_q ? -{acc_q, b_q} : {acc_q, b_q};
    assign quo_fix  = neg_q ? -b_q : b_q;
    assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

    always_comb begin
        sc_out  = '0;
        sc_hi   = '0;
        sc_ovf  = 1'b0;
        sc_cout = 1'b0;
        sc_ill  = 1'b0;
        multi   = 1'b0;
        case (op)
            OP_SLL:  sc_out = in0 << shamt;
            OP_SRL:  sc_out = in0 >> shamt;
            OP_SRA:  sc_out = $unsigned($signed(in0) >>> shamt);
            OP_SLLV: sc_out = in0 << in1[SHW-1:0];
            OP_SRLV: sc_out = in0 >> in1[SHW-1:0];
            OP_SRAV: sc_out = $unsigned($signed(in0) >>> in1[SHW-1:0]);
            OP_MULT, OP_MULTU: multi = 1'b1;
            OP_DIV, OP_DIVU: begin
                if (in1 == '0) begin
                    sc_out = '1;
                    sc_hi  = in0;
                    sc_ovf = 1'b1;
                end else begin
                    multi = 1'b1;
                end
            end
            OP_ADD:  begin sc_out = sum[WIDTH-1:0];  sc_ovf  = add_ovf;     end
            OP_ADDU: begin sc_out = sum[WIDTH-1:0];  sc_cout = sum[WIDTH];  end
            OP_SUB:  begin sc_out = diff[WIDTH-1:0]; sc_ovf  = sub_ovf;     end
            OP_SUBU: begin sc_out = diff[WIDTH-1:0]; sc_cout = diff[WIDTH]; end
            OP_AND:  sc_out = in0 & in1;
            OP_OR:   sc_out = in0 | in1;
            OP_XOR:  sc_out = in0 ^ in1;
            OP_NOR:  sc_out = ~(in0 | in1);
            OP_SLT:  sc_out = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            OP_SLTU: sc_out = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        acc_d     = acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div_ovf_d = div_ovf_q;
        out_d     = out_q;
        hi_d      = hi_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        cout_d    = cout_q;
        ill_d     = ill_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_DONE) && out_ready) state_d = S_IDLE;
                if (accept) begin
                    if (multi) begin
                        state_d   = S_CALC;
                        cnt_d     = SHW'(WIDTH-1);
                        acc_d     = '0;
                        is_div_d  = op[1];
                        a_d       = op[1] ? mag1 : mag0;
                        b_d       = op[1] ? mag0 : mag1;
                        neg_d     = s0 ^ s1;
                        neg_rem_d = s0;
                        div_ovf_d = (op == OP_DIV) && (in0 == MOST_NEG) && (in1 == '1);
                    end else begin
                        state_d = S_DONE;
                        out_d   = sc_out;
                        hi_d    = sc_hi;
                        ovf_d   = sc_ovf;
                        cout_d  = sc_cout;
                        ill_d   = sc_ill;
                        zero_d  = (sc_out == '0) & ~sc_ill;
                    end
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    if (!trial[WIDTH]) begin
                        acc_d = trial[WIDTH-1:0];
                        b_d   = {b_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[WIDTH-1:0];
                        b_d   = {b_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {acc_d, b_d} = {mul_sum, b_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d = cnt_q - SHW'(1);
            end
            S_FIX: begin
                state_d = S_DONE;
                cout_d  = 1'b0;
                ill_d   = 1'b0;
                if (is_div_q) begin
                    out_d  = quo_fix;
                    hi_d   = rem_fix;
                    ovf_d  = div_ovf_q;
                    zero_d = (quo_fix == '0);
                end else begin
                    out_d  = prod_fix[WIDTH-1:0];
                    hi_d   = prod_fix[2*WIDTH-1:WIDTH];
                    ovf_d  = 1'b0;
                    zero_d = (prod_fix == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div_ovf_q <= 1'b0;
            out_q     <= '0;
            hi_q      <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            cout_q    <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div_ovf_q <= div_ovf_d;
            out_q     <= out_d;
            hi_q      <= hi_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            cout_q    <= cout_d;
            ill_q     <= ill_d;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - Directed self-checking bench for alu_mc
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [31:0] in0, in1;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out, hi;
    logic        overflow, zero, carryout, illegal, busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mc #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in0(in0), .in1(in1), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .hi(hi),
        .overflow(overflow), .zero(zero), .carryout(carryout),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s);
        op = o; in0 = a; in1 = b; shamt = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles from the accept edge until out_valid (1 = visible right after accept).
    task automatic wait_result(output int lat, output bit rdy_seen);
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if ({out, hi} !== 64'h0) begin n_fail++; $display("FAIL reset_out_hi got %h want 0", {out, hi}); end
        n_checks++; if ({overflow, zero, carryout, illegal} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_flags got %b want 0000", {overflow, zero, carryout, illegal}); end
    endtask

    task automatic test_add_sub();
        int lat; bit rs;
        send(6'b100000, 32'h7FFFFFFF, 32'h1, 5'd0); wait_result(lat, rs);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d want 1", lat); end
        n_checks++; if ({out, overflow, zero, carryout} !== {32'h80000000, 3'b100}) begin n_fail++;
            $display("FAIL add_ovf got %h/%b%b%b want 80000000/100", out, overflow, zero, carryout); end
        consume();
        send(6'b100001, 32'hFFFFFFFF, 32'h1, 5'd0); wait_result(lat, rs);
        n_checks++; if ({out, overflow, zero, carryout} !== {32'h0, 3'b011}) begin n_fail++;
            $display("FAIL addu_carry got %h/%b%b%b want 00000000/011", out, overflow, zero, carryout); end
        consume();
        send(6'b100011, 32'd3, 32'd5, 5'd0); wait_result(lat, rs);
        n_checks++; if ({out, overflow, carryout} !== {32'hFFFFFFFE, 2'b01}) begin n_fail++;
            $display("FAIL subu_borrow got %h/%b%b want fffffffe/01", out, overflow, carryout); end
        consume();
        send(6'b100010, 32'h80000000, 32'h1, 5'd0); wait_result(lat, rs);
        n_checks++; if ({out, overflow, carryout} !== {32'h7FFFFFFF, 2'b10}) begin n_fail++;
            $display("FAIL sub_ovf got %h/%b%b want 7fffffff/10", out, overflow, carryout); end
        consume();
    endtask

    task automatic test_slt();
        int lat; bit rs;
        send(6'b101010, 32'h80000000, 32'h1, 5'd0); wait_result(lat, rs);
        n_checks++; if ({out, overflow, zero, carryout} !== {32'h1, 3'b000}) begin n_fail++;
            $display("FAIL slt got %h/%b%b%b want 00000001/000", out, overflow, zero, carryout); end
        consume();
        send(6'b101011, 32'h80000000, 32'h1, 5'd0); wait_result(lat, rs);
        n_checks++; if ({out, zero, carryout} !== {32'h0, 2'b10}) begin n_fail++;
            $display("FAIL sltu got %h/%b%b want 00000000/10", out, zero, carryout); end
        consume();
    endtask

    task automatic test_shift_logic();
        int lat; bit rs;
        send(6'b000111, 32'h80000000, 32'd35, 5'd0); wait_result(lat, rs);
        n_checks++; if (out !== 32'hF0000000) begin n_fail++; $display("FAIL srav got %h want f0000000", out); end
        consume();
        send(6'b000000, 32'h1, 32'h0, 5'd31); wait_result(lat, rs);
        n_checks++; if (out !== 32'h80000000) begin n_fail++; $display("FAIL sll got %h want 80000000", out); end
        consume();
        send(6'b000010, 32'h80000000, 32'h0, 5'd4); wait_result(lat, rs);
        n_checks++; if (out !== 32'h08000000) begin n_fail++; $display("FAIL srl got %h want 08000000", out); end
        consume();
        send(6'b100111, 32'h0, 32'h0, 5'd0); wait_result(lat, rs);
        n_checks++; if ({out, zero} !== {32'hFFFFFFFF, 1'b0}) begin n_fail++; $display("FAIL nor got %h/%b want ffffffff/0", out, zero); end
        consume();
        send(6'b100100, 32'h0000F0F0, 32'h00000F0F, 5'd0); wait_result(lat, rs);
        n_checks++; if ({out, zero} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL and_zero got %h/%b want 00000000/1", out, zero); end
        consume();
    endtask

    task automatic test_illegal();
        int lat; bit rs;
        send(6'b111111, 32'h5, 32'h6, 5'd0); wait_result(lat, rs);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL illegal_latency got %0d want 1", lat); end
        n_checks++; if ({out, hi, illegal, overflow, zero, carryout} !== {64'h0, 4'b1000}) begin n_fail++;
            $display("FAIL illegal got %h %h %b%b%b%b want 0 0 1000", out, hi, illegal, overflow, zero, carryout); end
        consume();
    endtask

    task automatic test_mult();
        int lat; bit rs;
        send(6'b011000, 32'hFFFFFFFD, 32'd7, 5'd0); wait_result(lat, rs);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency got %0d want 34", lat); end
        n_checks++; if (rs !== 1'b0) begin n_fail++; $display("FAIL mult_in_ready got %b want 0", rs); end
        n_checks++; if ({hi, out} !== 64'hFFFFFFFF_FFFFFFEB) begin n_fail++; $display("FAIL mult got %h want ffffffffffffffeb", {hi, out}); end
        consume();
        send(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0); wait_result(lat, rs);
        n_checks++; if ({hi, out, overflow, carryout, zero} !== {64'hFFFFFFFE_00000001, 3'b000}) begin n_fail++;
            $display("FAIL multu got %h/%b%b%b want fffffffe00000001/000", {hi, out}, overflow, carryout, zero); end
        consume();
        send(6'b011000, 32'h0, 32'd5, 5'd0); wait_result(lat, rs);
        n_checks++; if ({hi, out, zero} !== {64'h0, 1'b1}) begin n_fail++; $display("FAIL mult_zero got %h/%b want 0/1", {hi, out}, zero); end
        consume();
    endtask

    task automatic test_div();
        int lat; bit rs;
        send(6'b011010, 32'hFFFFFFF9, 32'd2, 5'd0); wait_result(lat, rs);
        n_checks++; if ({out, hi, overflow} !== {32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0}) begin n_fail++;
            $display("FAIL div_neg got %h/%h/%b want fffffffd/ffffffff/0", out, hi, overflow); end
        consume();
        send(6'b011010, 32'h80000000, 32'hFFFFFFFF, 5'd0); wait_result(lat, rs);
        n_checks++; if ({out, hi, overflow} !== {32'h80000000, 32'h0, 1'b1}) begin n_fail++;
            $display("FAIL div_most_neg got %h/%h/%b want 80000000/0/1", out, hi, overflow); end
        consume();
        send(6'b011011, 32'd9, 32'd0, 5'd0); wait_result(lat, rs);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL divz_latency got %0d want 1", lat); end
        n_checks++; if ({out, hi, overflow} !== {32'hFFFFFFFF, 32'd9, 1'b1}) begin n_fail++;
            $display("FAIL divu_zero got %h/%h/%b want ffffffff/9/1", out, hi, overflow); end
        consume();
        send(6'b011011, 32'd100, 32'd7, 5'd0); wait_result(lat, rs);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divu_latency got %0d want 34", lat); end
        n_checks++; if ({out, hi} !== {32'd14, 32'd2}) begin n_fail++; $display("FAIL divu got %h/%h want e/2", out, hi); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat; bit rs;
        out_ready = 1'b0;
        send(6'b100001, 32'd2, 32'd3, 5'd0); wait_result(lat, rs);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if ({out_valid, out, zero, carryout} !== {1'b1, 32'd5, 2'b00}) begin n_fail++;
                $display("FAIL hold_%0d got %b/%h want 1/00000005", i, out_valid, out); end
        end
        op = 6'b100110; in0 = 32'hFF; in1 = 32'h0F; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if ({out_valid, out} !== {1'b1, 32'hF0}) begin n_fail++;
            $display("FAIL b2b_result got %b/%h want 1/000000f0", out_valid, out); end
        @(posedge clk); #1;
        n_checks++; if ({out_valid, busy} !== 2'b00) begin n_fail++;
            $display("FAIL b2b_single got %b%b want 00", out_valid, busy); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        send(6'b011011, 32'd1000, 32'd3, 5'd0);
        repeat (10) begin @(posedge clk); #1; end
        n_checks++; if ({busy, in_ready} !== 2'b10) begin n_fail++; $display("FAIL calc_busy got %b%b want 10", busy, in_ready); end
        rst = 1'b1;
        #1;
        n_checks++; if ({out_valid, busy, overflow, zero, carryout, illegal} !== 6'b0) begin n_fail++;
            $display("FAIL rst_mid got %b%b%b%b%b%b want 000000", out_valid, busy, overflow, zero, carryout, illegal); end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_result got %0d want 0", seen); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; in0 = '0; in1 = '0; shamt = '0;
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_add_sub();
        test_slt();
        test_shift_logic();
        test_illegal();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU, the successor to the 32-bit combinational ALU. It keeps the MIPS funct-coded integer operations, generalised to WIDTH bits, and adds iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring). A valid/ready handshake sits on both the request and the result side, and all results and flags are registered. It sits between the decode/issue stage and writeback, with HI/LO supplied through the out/hi ports.

Parameters:
WIDTH, 32, operand/result width; power of two, minimum 8
SHW, 5, shift-amount width; must equal log2(WIDTH)

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready at a clk edge
op  in  6  funct code (table below)
in0  in  WIDTH  operand A / shift source
in1  in  WIDTH  operand B / variable shift amount (low SHW bits)
shamt  in  SHW  fixed shift amount for SLL/SRL/SRA
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready at a clk edge
out  out  WIDTH  result / LO / quotient
hi  out  WIDTH  HI of product / remainder; 0 for other ops
overflow  out  1  signed overflow (ADD/SUB); divide-by-zero (DIV/DIVU)
zero  out  1  result == 0 (MULT*: whole 2*WIDTH product == 0)
carryout  out  1  ADDU carry-out; SUBU borrow (in0 < in1 unsigned)
illegal  out  1  op not in table
busy  out  1  state != IDLE

Behaviour:
- op codes: SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011.
- Reset (async, immediate): state IDLE, out_valid 0, in_ready 1, and out, hi and all flags 0. Reset mid-operation abandons the operation with no result.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: on accept of a single-cycle op or an illegal op, go to DONE; out_valid rises on the cycle after acceptance (latency 1).
  - IDLE: on accept of MULT*/DIV* with nonzero divisor, go to CALC. Operands are latched; the signed variants latch magnitudes and record the result signs.
  - CALC: runs exactly WIDTH iterations (counter WIDTH-1 down to 0), one product bit or quotient bit per cycle, then goes to FIX.
  - FIX: applies two's-complement sign correction and computes flags, then goes to DONE. out_valid rises WIDTH+2 cycles after acceptance.
  - DONE: holds out, hi and flags stable while out_valid & !out_ready. On out_ready: if in_valid is also high, accept the new request the same edge; otherwise go to IDLE.
- in_ready = IDLE | (DONE & out_ready). in_ready is 0 in CALC/FIX, and requests presented then are ignored.
- Shifts: SLLV/SRLV/SRAV shift by in1[SHW-1:0] only; upper bits are ignored, so in1=35 with WIDTH=32 shifts by 3. SRA/SRAV replicate in0[WIDTH-1].
- ADD/SUB: overflow = operand signs agree (after inverting in1 for SUB) and result sign differs. carryout is 0 for the signed ops; overflow is 0 for the unsigned ops.
- SLT: out = (diff[msb] XOR sub_overflow), zero-extended. SLTU: out = borrow. For both, overflow and carryout are 0.
- Logic ops and shifts: overflow and carryout are 0; zero is derived from their own result.
- MULT/MULTU: {hi,out} = full 2*WIDTH product. Flags overflow and carryout are 0.
- DIV/DIVU: out = quotient truncated toward zero; hi = remainder, which takes the dividend's sign.
  - Divisor 0: out = all ones, hi = in0, overflow 1, latency 1 (skips CALC).
  - DIV with most-negative / -1: out = most-negative, hi 0, overflow 1.
- Illegal op: out 0, hi 0, illegal 1, other flags 0, latency 1.
- A result is never dropped or duplicated: exactly one out_valid handshake per accepted request.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> out 0x80000000, overflow 1, zero 0, out_valid 1 cycle after accept. ADDU 0xFFFFFFFF + 1 -> out 0, carryout 1, zero 1.
- SUBU 3 - 5 -> out 0xFFFFFFFE, carryout 1. SLT 0x80000000 vs 0x00000001 -> out 1. SLTU same operands -> out 0.
- SRAV in0 0x80000000, in1 35 -> 0xF0000000. SLL in0 0x00000001, shamt 31 -> 0x80000000. Op 111111 -> illegal 1, out 0.
- MULT -3 x 7 -> hi 0xFFFFFFFF, out 0xFFFFFFEB, out_valid exactly 34 cycles after accept, in_ready 0 throughout. MULTU 0xFFFFFFFF^2 -> hi 0xFFFFFFFE, out 0x00000001.
- DIV -7 / 2 -> out 0xFFFFFFFD, hi 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> out 0x80000000, overflow 1. DIVU 9 / 0 -> out 0xFFFFFFFF, hi 9, overflow 1, latency 1.
- Backpressure and reset:
  - Hold out_ready low 5 cycles in DONE -> outputs unchanged. Release with in_valid high -> new request accepted that edge, back-to-back.
  - Assert rst at CALC iteration 10 of DIVU -> out_valid, busy and flags 0 immediately, no result emitted, in_ready 1 after release.
